// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - EX-stage mul/div request/result bundle
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] opa_i;
    logic [WIDTH-1:0] opb_i;
    logic             flush_i;
    logic [WIDTH-1:0] result_o;
    logic             ready_o;
    logic             stallreq_o;

    // Pipeline side: drives the latched instruction, consumes result and stall
    modport master (
        output start_i, op_i, opa_i, opb_i, flush_i,
        input  result_o, ready_o, stallreq_o
    );

    // Unit side
    modport slave (
        input  start_i, op_i, opa_i, opb_i, flush_i,
        output result_o, ready_o, stallreq_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide unit for the EX stage
module ex_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    ex_muldiv_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    // Multiplicand magnitude for multiplies, divisor magnitude for divides
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    // Multiply: full product register. Divide: low half is dividend shifting
    // out while quotient bits shift in; high half stays zero.
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   result_q, result_d;

    // Operand decode for the instruction sitting in ID/EX
    logic               is_div;
    logic               a_signed, b_signed;
    logic               sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               sign_res;
    logic               div_zero, div_ovf;

    // Iteration datapath
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;

    // Final sign fix-up and output select
    logic [2*WIDTH-1:0] mul_fin;
    logic [WIDTH-1:0]   quo_fin;
    logic [WIDTH-1:0]   rem_fin;
    logic [WIDTH-1:0]   final_res;

    // Decode signedness, magnitudes and divide corner cases from the live inputs
    always_comb begin
        is_div   = bus.op_i[2];
        a_signed = (bus.op_i == OP_MULH) || (bus.op_i == OP_MULHSU) ||
                   (bus.op_i == OP_DIV)  || (bus.op_i == OP_REM);
        b_signed = (bus.op_i == OP_MULH) || (bus.op_i == OP_DIV) ||
                   (bus.op_i == OP_REM);
        sa       = a_signed & bus.opa_i[WIDTH-1];
        sb       = b_signed & bus.opb_i[WIDTH-1];
        mag_a    = sa ? -bus.opa_i : bus.opa_i;
        mag_b    = sb ? -bus.opb_i : bus.opb_i;
        case (bus.op_i)
            OP_MULH:   sign_res = sa ^ sb;
            OP_MULHSU: sign_res = sa;
            OP_DIV:    sign_res = sa ^ sb;
            OP_REM:    sign_res = sa;
            default:   sign_res = 1'b0;
        endcase
        div_zero = is_div && (bus.opb_i == '0);
        // Only the signed forms (op bit 0 clear) can overflow
        div_ovf  = is_div && !bus.op_i[0] &&
                   (bus.opa_i == MIN_NEG) && (bus.opb_i == ALL_ONES);
    end

    // One shift-add or one restoring shift-subtract step from the current state
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                    {1'b0, (prod_q[0] ? opnd_q : {WIDTH{1'b0}})};
        mul_next  = {mul_sum, prod_q[WIDTH-1:1]};
        div_shift = {rem_q, prod_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ok    = ~div_diff[WIDTH];
    end

    // Sign correction of the finished magnitude and result selection by op
    always_comb begin
        mul_fin = neg_q ? -prod_q : prod_q;
        quo_fin = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
        rem_fin = neg_q ? -rem_q : rem_q;
        case (op_q)
            OP_MUL:                       final_res = mul_fin[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = mul_fin[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              final_res = quo_fin;
            OP_REM, OP_REMU:              final_res = rem_fin;
            default:                      final_res = {WIDTH{1'b0}};
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        neg_d    = neg_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i && !bus.flush_i) begin
                    op_d  = bus.op_i;
                    cnt_d = '0;
                    rem_d = '0;
                    neg_d = sign_res;
                    if (is_div) begin
                        opnd_d = mag_b;
                        prod_d = {{WIDTH{1'b0}}, mag_a};
                    end else begin
                        opnd_d = mag_a;
                        prod_d = {{WIDTH{1'b0}}, mag_b};
                    end
                    // op bit 1 distinguishes REM/REMU from DIV/DIVU
                    if (div_zero) begin
                        result_d = bus.op_i[1] ? bus.opa_i : ALL_ONES;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = bus.op_i[1] ? {WIDTH{1'b0}} : MIN_NEG;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == LAST_CNT) begin
                    result_d = final_res;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (op_q[2]) begin
                        rem_d  = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        prod_d = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-2:0], div_ok};
                    end else begin
                        prod_d = mul_next;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            opnd_q   <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    // Stall is gated by reset so a held start_i cannot stall the pipe while in reset
    always_comb begin
        bus.stallreq_o = rst && (((state_q == S_IDLE) && bus.start_i && !bus.flush_i) ||
                                 (state_q == S_BUSY));
        bus.ready_o    = (state_q == S_DONE) && !bus.flush_i;
        bus.result_o   = result_q;
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed self-checking bench for ex_muldiv
module tb_ex_muldiv;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    ex_muldiv_if #(.WIDTH(32)) bus ();

    ex_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          stalls;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Issue one instruction, hold start until ready, corrupt inputs mid-BUSY
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int stalls,
                          output bit got, output bit stall_in_done);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.opa_i   = a;
        bus.opb_i   = b;
        #1;
        stalls = 0;
        got = 1'b0;
        res = '0;
        stall_in_done = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            if (bus.ready_o) begin
                got = 1'b1;
                res = bus.result_o;
                stall_in_done = bus.stallreq_o;
            end else begin
                if (bus.stallreq_o) stalls++;
                @(negedge clk);
                if (c == 4) begin
                    bus.opa_i = ~a;
                    bus.opb_i = b ^ 32'h5;
                    bus.op_i  = op ^ 3'b001;
                end
                #1;
            end
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] res;
        int          stalls;
        int          pulses;
        int          gap;
        bit          got;
        bit          sdone;

        n_pass  = 0;
        n_total = 0;

        vecs[0]  = '{3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34};
        vecs[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
        vecs[2]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 34};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34};
        vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       34};
        vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        34};
        vecs[8]  = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[9]  = '{3'b110, 32'd5,        32'd0,        32'd5,        1};
        vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
        vecs[12] = '{3'b100, 32'h80000000, 32'h00000002, 32'hC0000000, 34};
        vecs[13] = '{3'b111, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 34};

        // Reset state, with start held high to show stall is suppressed
        rst_n       = 1'b0;
        bus.start_i = 1'b1;
        bus.op_i    = 3'b000;
        bus.opa_i   = 32'd1;
        bus.opb_i   = 32'd1;
        bus.flush_i = 1'b0;
        #1;
        check("reset_result", bus.result_o, 32'h0);
        check("reset_ready", {31'b0, bus.ready_o}, 32'h0);
        check("reset_stall", {31'b0, bus.stallreq_o}, 32'h0);
        repeat (2) @(negedge clk);
        bus.start_i = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, stalls, got, sdone);
            check($sformatf("vec%0d_ready_seen", i), {31'b0, got}, 32'd1);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_stall_cycles", i), stalls, vecs[i].stalls);
            check($sformatf("vec%0d_stall_in_done", i), {31'b0, sdone}, 32'd0);
            check($sformatf("vec%0d_ready_one_cycle", i), {31'b0, bus.ready_o}, 32'd0);
            check($sformatf("vec%0d_result_held", i), bus.result_o, vecs[i].exp);
        end

        // Flush at the 10th BUSY cycle
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 3'b000;
        bus.opa_i   = 32'd5;
        bus.opb_i   = 32'd6;
        repeat (10) @(negedge clk);
        bus.flush_i = 1'b1;
        bus.start_i = 1'b0;
        #1;
        check("flush_no_ready_in_flush", {31'b0, bus.ready_o}, 32'd0);
        @(negedge clk);
        bus.flush_i = 1'b0;
        #1;
        check("flush_stall_low", {31'b0, bus.stallreq_o}, 32'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.ready_o) pulses++;
            @(negedge clk);
            #1;
        end
        check("flush_no_ready_pulse", pulses, 0);

        run_op(3'b000, 32'd3, 32'd4, res, stalls, got, sdone);
        check("mul3x4_ready_seen", {31'b0, got}, 32'd1);
        check("mul3x4_result", res, 32'd12);
        check("mul3x4_stall_cycles", stalls, 34);

        // Asynchronous reset in the middle of BUSY
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 3'b101;
        bus.opa_i   = 32'd100;
        bus.opb_i   = 32'd7;
        repeat (5) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_result", bus.result_o, 32'h0);
        check("async_rst_ready", {31'b0, bus.ready_o}, 32'h0);
        check("async_rst_stall", {31'b0, bus.stallreq_o}, 32'h0);
        @(negedge clk);
        bus.start_i = 1'b0;
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus.ready_o) pulses++;
            @(negedge clk);
        end
        check("async_rst_no_ready", pulses, 0);

        // Back-to-back DIVU with start held across both instructions
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 3'b101;
        bus.opa_i   = 32'd100;
        bus.opb_i   = 32'd7;
        #1;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            if (bus.ready_o) got = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
        check("b2b_first_seen", {31'b0, got}, 32'd1);
        check("b2b_first_result", bus.result_o, 32'd14);
        @(negedge clk);
        bus.opa_i = 32'd50;
        bus.opb_i = 32'd5;
        #1;
        check("b2b_idle_ready_low", {31'b0, bus.ready_o}, 32'd0);
        check("b2b_idle_accept_stall", {31'b0, bus.stallreq_o}, 32'd1);
        gap = 1;
        while (!bus.ready_o && gap < 100) begin
            @(negedge clk);
            #1;
            gap++;
        end
        check("b2b_gap_cycles", gap, 35);
        check("b2b_second_result", bus.result_o, 32'd10);
        @(negedge clk);
        bus.start_i = 1'b0;
        #1;
        check("b2b_second_pulse_ends", {31'b0, bus.ready_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
